// File: rtl/multicycle_control.sv
// Moore sequencing controller for the multicycle RISC-V core: steps one instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 onto result bus; waits on memReady
// DECODE   | oldPC + imm precomputes branch/jump target
// MEMADR   | rs1 + imm computes load/store address
// MEMREAD  | load access at ALU result register; waits on memReady
// MEMWRITE | store access, memWrite held; waits on memReady
// MEMWB    | memory data register written to rd
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | ALU result register written to rd
// BEQ      | rs1 - rs2, PC loaded from target when zero
// JAL      | oldPC + 4 computed, PC loaded from target
// TRAP     | unsupported opcode, held until reset

module multicycle_control (
  input  logic       clk,
  input  logic       resetN,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [1:0] immSrc,
  output logic [2:0] ALUcontrol,
  output logic       illegalInstr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (memReady) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (memReady) state_next = MEMWB;
      MEMWRITE: if (memReady) state_next = FETCH;
      EXECR, EXECI, JAL: state_next = ALUWB;
      MEMWB, ALUWB, BEQ: state_next = FETCH;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    memReq       = 1'b0;
    memWrite     = 1'b0;
    adrSrc       = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    regWrite     = 1'b0;
    aluSrcA      = 2'b00;
    aluSrcB      = 2'b00;
    resultSrc    = 2'b00;
    alu_op       = 2'b00;
    illegalInstr = 1'b0;
    case (state)
      FETCH: begin
        memReq    = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irWrite   = memReady;
        pcWrite   = memReady;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      MEMREAD: begin
        memReq = 1'b1;
        adrSrc = 1'b1;
      end
      MEMWRITE: begin
        memReq   = 1'b1;
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
      end
      EXECR: begin
        aluSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      ALUWB:    regWrite = 1'b1;
      BEQ: begin
        aluSrcA = 2'b10;
        alu_op  = 2'b01;
        pcWrite = zero;
      end
      JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
      end
      TRAP:     illegalInstr = 1'b1;
      default: ;
    endcase
  end

  // sub for R-type only: I-type reuses funct7 bit as immediate data
  always_comb begin
    ALUcontrol = 3'b000;
    case (alu_op)
      2'b01: ALUcontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUcontrol = (op[5] && funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUcontrol = 3'b101;
          3'b110:  ALUcontrol = 3'b011;
          3'b111:  ALUcontrol = 3'b010;
          default: ALUcontrol = 3'b000;
        endcase
      end
      default: ALUcontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle plans derived from the
// instruction's meaning, replayed against the controller one cycle at a time.

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       resetN;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic       memReady;
  logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegalInstr;
  logic [1:0] aluSrcA, aluSrcB, resultSrc, immSrc;
  logic [2:0] ALUcontrol;

  multicycle_control dut (
    .clk(clk), .resetN(resetN), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .memReady(memReady), .memReq(memReq), .memWrite(memWrite),
    .adrSrc(adrSrc), .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .resultSrc(resultSrc), .immSrc(immSrc),
    .ALUcontrol(ALUcontrol), .illegalInstr(illegalInstr)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1110011;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] obs;
  assign obs = {memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, aluSrcA,
                aluSrcB, resultSrc, immSrc, ALUcontrol, illegalInstr};

  task automatic check_val(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation the instruction itself asks for
  function automatic logic [2:0] alu_of_instr();
    case (funct3)
      3'b000:  return (op == RT && funct7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [17:0] ev(input logic req, wr, adr, ir, pc, rw,
                                     input logic [1:0] a, b, r,
                                     input logic [2:0] alu, input logic ill);
    return {req, wr, adr, ir, pc, rw, a, b, r, imm_of(op), alu, ill};
  endfunction

  logic [17:0] exp_q[$];
  bit          mr_q[$];

  task automatic push(input bit mr, input logic [17:0] e);
    mr_q.push_back(mr);
    exp_q.push_back(e);
  endtask

  task automatic plan_mem(input int stall, input logic [17:0] e);
    for (int i = 0; i < stall; i++) push(1'b0, e);
    push(1'b1, e);
  endtask

  task automatic plan_instr(input int fstall, input int mstall);
    logic [17:0] aluwb;
    aluwb = ev(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    exp_q.delete();
    mr_q.delete();
    for (int i = 0; i < fstall; i++) push(1'b0, ev(1,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    push(1'b1, ev(1,0,0,1,1,0, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    push($urandom_range(0,1), ev(0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 3'b000, 0));
    case (op)
      LW: begin
        push($urandom_range(0,1), ev(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        plan_mem(mstall, ev(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        push($urandom_range(0,1), ev(0,0,0,0,0,1, 2'b00, 2'b00, 2'b01, 3'b000, 0));
      end
      SW: begin
        push($urandom_range(0,1), ev(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        plan_mem(mstall, ev(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      end
      RT: begin
        push($urandom_range(0,1), ev(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, alu_of_instr(), 0));
        push($urandom_range(0,1), aluwb);
      end
      IT: begin
        push($urandom_range(0,1), ev(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, alu_of_instr(), 0));
        push($urandom_range(0,1), aluwb);
      end
      BQ: push($urandom_range(0,1), ev(0,0,0,0,zero,0, 2'b10, 2'b00, 2'b00, 3'b001, 0));
      JL: begin
        push($urandom_range(0,1), ev(0,0,0,0,1,0, 2'b01, 2'b10, 2'b00, 3'b000, 0));
        push($urandom_range(0,1), aluwb);
      end
      default:
        for (int i = 0; i < 20; i++)
          push($urandom_range(0,1), ev(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1));
    endcase
  endtask

  // replay the first n planned cycles (all when n < 0)
  task automatic replay(input string name, input int n);
    int lim;
    lim = (n < 0 || n > exp_q.size()) ? exp_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      memReady = mr_q[i];
      @(negedge clk);
      check_val($sformatf("%s c%0d", name, i), obs, exp_q[i]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7 = f7; zero = z;
  endtask

  task automatic run(input string name, input int fstall, input int mstall);
    plan_instr(fstall, mstall);
    replay(name, -1);
  endtask

  task automatic reset_check(input string name);
    memReady = 1'b0;
    #2 resetN = 1'b0;
    #1 check_val({name, " rst"}, obs, ev(1,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    memReady = 1'b1;
    #1 check_val({name, " rst rdy"}, obs, ev(1,0,0,1,1,0, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    memReady = 1'b0;
    #1 resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] legal_ops [6];

  initial begin
    legal_ops[0] = LW; legal_ops[1] = SW; legal_ops[2] = RT;
    legal_ops[3] = IT; legal_ops[4] = BQ; legal_ops[5] = JL;
    resetN = 1'b0;
    memReady = 1'b0;
    set_instr(RT, 3'b000, 1'b0, 1'b0);
    #3 check_val("reset fetch", obs, ev(1,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    memReady = 1'b1;
    #1 check_val("reset irwrite", obs, ev(1,0,0,1,1,0, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    memReady = 1'b0;
    #4 resetN = 1'b1;
    @(posedge clk);
    #1;

    run("add", 0, 0);
    set_instr(LW, 3'b010, 1'b0, 1'b0);
    run("lw stall", 2, 3);
    set_instr(BQ, 3'b000, 1'b0, 1'b1);
    run("beq taken", 0, 0);
    set_instr(BQ, 3'b000, 1'b0, 1'b0);
    run("beq not", 1, 0);
    set_instr(RT, 3'b000, 1'b1, 1'b0);
    run("sub", 0, 0);
    set_instr(IT, 3'b000, 1'b1, 1'b0);
    run("addi f7", 0, 0);
    set_instr(IT, 3'b110, 1'b0, 1'b0);
    run("ori", 0, 0);
    set_instr(IT, 3'b010, 1'b0, 1'b0);
    run("slti", 0, 0);
    set_instr(IT, 3'b111, 1'b0, 1'b0);
    run("andi", 0, 0);
    set_instr(JL, 3'b000, 1'b0, 1'b0);
    run("jal", 0, 0);

    // sw stalled in MEMWRITE, aborted by reset in its 3rd memWrite cycle
    set_instr(SW, 3'b010, 1'b0, 1'b0);
    plan_instr(0, 4);
    replay("sw abort", 5);
    memReady = 1'b0;
    #2 check_val("sw memwrite held", {17'b0, memWrite}, 18'd1);
    resetN = 1'b0;
    #1 check_val("sw memwrite drop", {17'b0, memWrite}, 18'd0);
    check_val("sw abort fetch", obs, ev(1,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    #2 resetN = 1'b1;
    @(posedge clk);
    #1;
    run("sw after abort", 1, 2);

    set_instr(BAD, 3'b000, 1'b0, 1'b0);
    run("trap", 0, 0);
    reset_check("trap clear");

    for (int k = 0; k < 60; k++) begin
      set_instr(legal_ops[$urandom_range(0,5)], 3'($urandom), 1'($urandom), 1'($urandom));
      run($sformatf("rnd%0d op%b", k, op), $urandom_range(0,3), $urandom_range(0,3));
    end

    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    run("trap2", 2, 0);
    reset_check("trap2 clear");
    set_instr(RT, 3'b111, 1'b0, 1'b0);
    run("and after trap", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
